// File: rtl/sync_fifo_param_if.sv
// rtl/sync_fifo_param_if.sv - Handshake and status bundle for sync_fifo_param
interface sync_fifo_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  w_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  r_en;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output w_en, data_in, r_en, clr_err,
    input  data_out, data_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  w_en, data_in, r_en, clr_err,
    output data_out, data_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - Single-clock parametrised FIFO with thresholds and sticky errors
module sync_fifo_param #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 4
) (
  input logic             clk,
  input logic             rst,
  sync_fifo_param_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AFULL_LVL  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_LVL = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH:0]   fill;
  logic                  is_full;
  logic                  is_empty;
  logic                  wr_accept;
  logic                  rd_accept;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  data_valid_q;
  logic                  overflow_q;
  logic                  underflow_q;

  // Wrap bit distinguishes full from empty when the address bits coincide.
  assign fill     = wr_ptr - rd_ptr;
  assign is_empty = (wr_ptr == rd_ptr);
  assign is_full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                    (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

  assign wr_accept = bus.w_en && !is_full;
  assign rd_accept = bus.r_en && !is_empty;

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else if (rd_accept) begin
      data_out_q   <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      data_valid_q <= 1'b1;
    end else begin
      data_valid_q <= 1'b0;
    end
  end

  // A new error event in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.clr_err) begin
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end
      if (bus.w_en && is_full) begin
        overflow_q <= 1'b1;
      end
      if (bus.r_en && is_empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.data_valid   = data_valid_q;
  assign bus.full         = is_full;
  assign bus.empty        = is_empty;
  assign bus.almost_full  = (fill >= AFULL_LVL);
  assign bus.almost_empty = (fill <= AEMPTY_LVL);
  assign bus.count        = fill;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Single-clock, parametrised FIFO for same-domain buffering. Next generation of the team's FIFO: configurable data width and depth, fill count, programmable almost-full/almost-empty thresholds, registered read data with a valid strobe, and sticky overflow/underflow error flags. Intended for producer/consumer paths where both sides share one clock and need early back-pressure.

## Interface
- DATA_WIDTH, 8, width of data_in / data_out
- ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH entries (default 16)
- AFULL_THRESH, 12, almost_full asserts when count >= this (1..DEPTH)
- AEMPTY_THRESH, 4, almost_empty asserts when count <= this (0..DEPTH-1)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- w_en  in  1  write request
- data_in  in  DATA_WIDTH  write data
- r_en  in  1  read request
- data_out  out  DATA_WIDTH  registered read data
- data_valid  out  1  one-cycle strobe: data_out updated by an accepted read
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AFULL_THRESH
- almost_empty  out  1  count <= AEMPTY_THRESH
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty
- clr_err  in  1  clears overflow/underflow

## Operation
- Storage: DEPTH x DATA_WIDTH register array; contents not reset.
- Pointers: wr_ptr, rd_ptr, each ADDR_WIDTH+1 bits binary; low ADDR_WIDTH bits address memory; MSB is the wrap bit.
- empty: wr_ptr == rd_ptr. full: MSBs differ, low bits equal. count = wr_ptr - rd_ptr (modulo 2**(ADDR_WIDTH+1)).
- Write accepted iff w_en && !full: mem[wr_ptr] <= data_in, wr_ptr += 1.
- Read accepted iff r_en && !empty: data_out <= mem[rd_ptr], rd_ptr += 1, data_valid <= 1; otherwise data_valid <= 0 and data_out holds.
- Acceptance uses flag state before the edge. Simultaneous w_en && r_en:
  - neither full nor empty: both accepted, count unchanged;
  - full: read accepted, write rejected and sets overflow;
  - empty: write accepted, read rejected and sets underflow.
- Rejected requests never move pointers or memory.
- overflow <= 1 on w_en && full; underflow <= 1 on r_en && empty; clr_err clears both; set wins over clr_err in the same cycle.
- Pointer wrap is natural binary roll-over; no special handling.

## Timing
- Reset (rst high at edge): wr_ptr=rd_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, data_out=0, data_valid=0, overflow=0, underflow=0. w_en/r_en/clr_err ignored while rst high. Reset mid-operation discards all contents at that edge.
- Flags and count are decoded from registered pointers; they reflect an accepted operation on the output side of the same edge that performs it.
- Write-to-read: write accepted at edge N -> empty=0 after N -> read accepted at N+1 -> data_out/data_valid valid after N+1.
- Read latency: 1 cycle from accepted r_en to data_out; data_valid high exactly one cycle per accepted read.
- Throughput: one write and one read per cycle sustained.

## Test plan
- Reset: assert rst 2 cycles mid-stream with count=5 -> count=0, empty=1, almost_empty=1, data_valid=0, flags cleared; subsequent read with r_en=1 -> underflow=1, data_valid=0.
- Fill/drain (defaults): write 0x00..0x0F on 16 cycles -> almost_full at count=12, full at count=16; 17th write -> overflow=1, count stays 16; read 16 -> data_out 0x00..0x0F in order, one data_valid each, empty after last.
- Wrap: write 10, read 10, write 10, read 10 -> data in order across pointer roll-over, count returns to 0, no error flags.
- Simultaneous at full: full FIFO, w_en=r_en=1 one cycle -> count=15, overflow=1, data_out=oldest entry; at empty, w_en=r_en=1 -> count=1, underflow=1, data_valid=0.
- Streaming: count=3, w_en=r_en=1 for 20 cycles -> count constant 3, data_valid high every cycle, data order preserved.
- Error clear: overflow=1, pulse clr_err -> overflow=0; clr_err with concurrent write-at-full -> overflow stays 1.
